add_pg_pipe: RTL

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit propagate/generate groups. Generalises the fixed 16-bit two-level lookahead adder to WIDTH bits and splits the group carry chain across STAGES register boundaries, with a valid/ready handshake on both sides. It produces the sum/difference, raw carry, signed overflow and word-level propagate/generate flags, and sits in the datapath wherever a wide add must close timing at full clock rate.

---
 rtl/add_pg_pipe_if.sv | 39 +++
 rtl/add_pg_pipe.sv | 128 ++++++++++++
 2 files changed

// File: rtl/add_pg_pipe_if.sv
// add_pg_pipe_if: operand/result handshake bundle for add_pg_pipe.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the adder pipeline (drives in_ready and the result fields)
// Signals:
//   in_valid/in_ready     operand beat handshake
//   val1/val2             operands A and B (WIDTH bits)
//   carry_in, sub, sat    carry/borrow in, subtract select, saturation request
//   out_valid/out_ready   result beat handshake
//   val_out               sum/difference (WIDTH bits)
//   carry_out, ovf_out    raw carry out of MSB, signed overflow
//   prop_out, gen_out     word-level propagate / generate
interface add_pg_pipe_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] val1;
   logic [WIDTH-1:0] val2;
   logic             carry_in;
   logic             sub;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] val_out;
   logic             carry_out;
   logic             ovf_out;
   logic             prop_out;
   logic             gen_out;

   modport master (
      output in_valid, val1, val2, carry_in, sub, sat, out_ready,
      input  in_ready, out_valid, val_out, carry_out, ovf_out, prop_out, gen_out
   );

   modport slave (
      input  in_valid, val1, val2, carry_in, sub, sat, out_ready,
      output in_ready, out_valid, val_out, carry_out, ovf_out, prop_out, gen_out
   );
endinterface

// File: rtl/add_pg_pipe.sv
// add_pg_pipe: pipelined carry-lookahead adder/subtractor built from 4-bit
// propagate/generate groups. The group carry chain is split evenly across
// STAGES register boundaries; the last boundary is the output register.
// Optional feature macro: ADD_PG_PIPE_SAT_EN (signed saturation of val_out
// when the beat's sat bit is set and overflow occurs).
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   add_pg_pipe_if.slave (operand/result handshake and data)
// Parameters:
//   WIDTH   operand width, multiple of 4, 8..64
//   STAGES  pipeline depth, divides WIDTH/4
module add_pg_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   add_pg_pipe_if.slave  bus
);

   localparam int unsigned NGRP = WIDTH / 4;
   localparam int unsigned GPS  = NGRP / STAGES;

   // One pipeline slot. a/b hold the effective operands (b already inverted
   // for subtract), c is the running group carry, p/g the running word
   // propagate/generate, s the sum bits finished so far.
   typedef struct packed {
      logic             v;
      logic             sat;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] s;
      logic             c;
      logic             p;
      logic             g;
      logic             ovf;
   } stage_t;

   stage_t pipe_q [STAGES];
   stage_t pipe_d [STAGES];
   stage_t stg_in [STAGES];
   logic   adv;

   // Evaluate the G groups owned by stage k on top of the incoming slot.
   function automatic stage_t eval_stage(input stage_t in, input int unsigned k);
      stage_t      o;
      logic [3:0]  pb;
      logic [3:0]  gb;
      logic [4:0]  rc;
      logic        gp;
      logic        gg;
      int unsigned base;
      o = in;
      for (int unsigned j = 0; j < GPS; j++) begin
         base  = (k * GPS + j) * 4;
         pb    = o.a[base +: 4] ^ o.b[base +: 4];
         gb    = o.a[base +: 4] & o.b[base +: 4];
         rc[0] = o.c;
         for (int unsigned i = 0; i < 4; i++) begin
            rc[i+1] = gb[i] | (pb[i] & rc[i]);
         end
         o.s[base +: 4] = pb ^ rc[3:0];
         gp  = &pb;
         gg  = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);
         o.c = gg | (gp & o.c);
         o.p = o.p & gp;
         // Accumulating LSB-group upward yields the MSB-down lookahead combine.
         o.g = gg | (gp & o.g);
         if (k * GPS + j == NGRP - 1) begin
            // rc[3] is the carry into the MSB of the top group.
            o.ovf = rc[3] ^ o.c;
         end
      end
`ifdef ADD_PG_PIPE_SAT_EN
      if (k == STAGES - 1 && o.sat && o.ovf) begin
         o.s = o.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      return o;
   endfunction

   always_comb begin
      stg_in[0]     = '0;
      stg_in[0].v   = bus.in_valid;
`ifdef ADD_PG_PIPE_SAT_EN
      stg_in[0].sat = bus.sat;
`else
      stg_in[0].sat = 1'b0;
`endif
      stg_in[0].a   = bus.val1;
      stg_in[0].b   = bus.sub ? ~bus.val2 : bus.val2;
      stg_in[0].c   = bus.sub ? ~bus.carry_in : bus.carry_in;
      stg_in[0].p   = 1'b1;
      stg_in[0].g   = 1'b0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         stg_in[k] = pipe_q[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
         pipe_d[k] = eval_stage(stg_in[k], k);
      end
   end

   // Whole pipeline advances together; bubbles ride along uncollapsed.
   assign adv = bus.out_ready | ~pipe_q[STAGES-1].v;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            pipe_q[k] <= '0;
         end
      end else if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            pipe_q[k] <= pipe_d[k];
         end
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = pipe_q[STAGES-1].v;
   assign bus.val_out   = pipe_q[STAGES-1].s;
   assign bus.carry_out = pipe_q[STAGES-1].c;
   assign bus.ovf_out   = pipe_q[STAGES-1].ovf;
   assign bus.prop_out  = pipe_q[STAGES-1].p;
   assign bus.gen_out   = pipe_q[STAGES-1].g;

endmodule
